// File: rtl/hwpe_cfg_arbiter.sv
// hwpe_cfg_arbiter: round-robin arbiter that funnels N_REQ requesters onto a
// single HWPE configuration slave port. One transaction is in flight at a
// time. Downstream ids carry an epoch bit plus the owner index, so that late
// responses from an abandoned or timed-out transaction can be filtered out.
module hwpe_cfg_arbiter #(
  parameter int N_REQ    = 9,
  parameter int ID_WIDTH = 8,
  parameter int TIMEOUT  = 255
) (
  input  logic                             clk_i,
  input  logic                             rst_i,
  input  logic [N_REQ-1:0]                 req_i,
  input  logic [N_REQ-1:0][31:0]           add_i,
  input  logic [N_REQ-1:0]                 wen_i,
  input  logic [N_REQ-1:0][3:0]            be_i,
  input  logic [N_REQ-1:0][31:0]           wdata_i,
  input  logic [N_REQ-1:0][ID_WIDTH-1:0]   id_i,
  output logic [N_REQ-1:0]                 gnt_o,
  output logic [N_REQ-1:0]                 r_valid_o,
  output logic [31:0]                      r_rdata_o,
  output logic [ID_WIDTH-1:0]              r_id_o,
  output logic                             r_opc_o,
  output logic                             cfg_req_o,
  output logic [31:0]                      cfg_add_o,
  output logic                             cfg_wen_o,
  output logic [3:0]                       cfg_be_o,
  output logic [31:0]                      cfg_data_o,
  output logic [ID_WIDTH-1:0]              cfg_id_o,
  input  logic                             cfg_gnt_i,
  input  logic                             cfg_r_valid_i,
  input  logic [31:0]                      cfg_r_data_i,
  input  logic [ID_WIDTH-1:0]              cfg_r_id_i,
  output logic                             busy_o
);

  localparam int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TIMEOUT - 1);
  localparam logic [31:0] TIMEOUT_DATA = 32'hBADACCE5;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT_R, RESP} state_t;

  state_t               state_q, state_d;
  logic [IDX_W-1:0]     rr_ptr_q;
  logic                 epoch_q;
  logic [CNT_W-1:0]     cnt_q;
  logic [IDX_W-1:0]     owner_q;
  logic [31:0]          add_q;
  logic                 wen_q;
  logic [3:0]           be_q;
  logic [31:0]          wdata_q;
  logic [ID_WIDTH-1:0]  uid_q;
  logic [31:0]          rdata_q;
  logic [ID_WIDTH-1:0]  rid_q;
  logic                 err_q;

  logic                 win_found;
  logic [IDX_W-1:0]     win_idx;
  logic [IDX_W-1:0]     ptr_next;
  int                   cand;
  logic [ID_WIDTH-1:0]  issued_id;
  logic                 id_match;
  logic                 take;
  logic                 accept;
  logic                 time_out;
  logic                 live;

  // Round-robin search: first requester at or above rr_ptr, wrapping around.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    cand      = 0;
    for (int i = 0; i < N_REQ; i++) begin
      cand = int'(rr_ptr_q) + i;
      if (cand >= N_REQ) cand = cand - N_REQ;
      if (!win_found && req_i[cand]) begin
        win_found = 1'b1;
        win_idx   = IDX_W'(cand);
      end
    end
  end

  assign ptr_next  = (int'(win_idx) == N_REQ - 1) ? '0 : win_idx + 1'b1;
  assign issued_id = ID_WIDTH'({epoch_q, owner_q});
  assign id_match  = (cfg_r_id_i == issued_id);

  // Next-state logic; a matching response always beats the timeout.
  always_comb begin
    state_d  = state_q;
    take     = 1'b0;
    accept   = 1'b0;
    time_out = 1'b0;
    case (state_q)
      IDLE: begin
        if (win_found) begin
          take    = 1'b1;
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        if (cfg_gnt_i && cfg_r_valid_i && id_match) begin
          accept  = 1'b1;
          state_d = RESP;
        end else if (cnt_q == TO_LAST) begin
          time_out = 1'b1;
          state_d  = RESP;
        end else if (cfg_gnt_i) begin
          state_d = WAIT_R;
        end
      end
      WAIT_R: begin
        if (cfg_r_valid_i && id_match) begin
          accept  = 1'b1;
          state_d = RESP;
        end else if (cnt_q == TO_LAST) begin
          time_out = 1'b1;
          state_d  = RESP;
        end
      end
      RESP: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State, request latch, timeout counter and response registers.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q  <= IDLE;
      rr_ptr_q <= '0;
      epoch_q  <= 1'b0;
      cnt_q    <= '0;
      owner_q  <= '0;
      add_q    <= '0;
      wen_q    <= 1'b0;
      be_q     <= '0;
      wdata_q  <= '0;
      uid_q    <= '0;
      rdata_q  <= '0;
      rid_q    <= '0;
      err_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      if (take) begin
        owner_q  <= win_idx;
        add_q    <= add_i[win_idx];
        wen_q    <= wen_i[win_idx];
        be_q     <= be_i[win_idx];
        wdata_q  <= wdata_i[win_idx];
        uid_q    <= id_i[win_idx];
        rr_ptr_q <= ptr_next;
        cnt_q    <= '0;
      end else if (state_q == ISSUE || state_q == WAIT_R) begin
        cnt_q <= cnt_q + 1'b1;
      end
      if (accept) begin
        rdata_q <= cfg_r_data_i;
        err_q   <= 1'b0;
      end else if (time_out) begin
        rdata_q <= TIMEOUT_DATA;
        err_q   <= 1'b1;
      end
      if (accept || time_out) begin
        rid_q   <= uid_q;
        epoch_q <= ~epoch_q;
      end
    end
  end

  // Outputs other than the grant are forced low while reset is held.
  assign live       = ~rst_i;
  assign gnt_o      = (state_q == IDLE && win_found) ? (N_REQ'(1) << win_idx) : '0;
  assign r_valid_o  = (live && state_q == RESP) ? (N_REQ'(1) << owner_q) : '0;
  assign r_opc_o    = live && (state_q == RESP) && err_q;
  assign r_rdata_o  = live ? rdata_q : '0;
  assign r_id_o     = live ? rid_q : '0;
  assign cfg_req_o  = live && (state_q == ISSUE);
  assign cfg_add_o  = live ? add_q : '0;
  assign cfg_wen_o  = live && wen_q;
  assign cfg_be_o   = live ? be_q : '0;
  assign cfg_data_o = live ? wdata_q : '0;
  assign cfg_id_o   = live ? issued_id : '0;
  assign busy_o     = live && (state_q != IDLE);

endmodule

// File: tb/tb_hwpe_cfg_arbiter.sv
// tb_hwpe_cfg_arbiter: transaction-level reference model of the arbiter,
// driving directed scenarios and randomized traffic on a TIMEOUT=4 instance.
module tb_hwpe_cfg_arbiter;

  localparam int N   = 9;
  localparam int IDW = 8;
  localparam int TO  = 4;

  logic                     clk = 1'b0;
  logic                     rst;
  logic [N-1:0]             req_i;
  logic [N-1:0][31:0]       add_i;
  logic [N-1:0]             wen_i;
  logic [N-1:0][3:0]        be_i;
  logic [N-1:0][31:0]       wdata_i;
  logic [N-1:0][IDW-1:0]    id_i;
  logic [N-1:0]             gnt_o;
  logic [N-1:0]             r_valid_o;
  logic [31:0]              r_rdata_o;
  logic [IDW-1:0]           r_id_o;
  logic                     r_opc_o;
  logic                     cfg_req_o;
  logic [31:0]              cfg_add_o;
  logic                     cfg_wen_o;
  logic [3:0]               cfg_be_o;
  logic [31:0]              cfg_data_o;
  logic [IDW-1:0]           cfg_id_o;
  logic                     cfg_gnt_i;
  logic                     cfg_r_valid_i;
  logic [31:0]              cfg_r_data_i;
  logic [IDW-1:0]           cfg_r_id_i;
  logic                     busy_o;

  int checks   = 0;
  int failures = 0;
  int ptr_m    = 0;
  bit epoch_m  = 1'b0;

  always #5 clk = ~clk;

  hwpe_cfg_arbiter #(.N_REQ(N), .ID_WIDTH(IDW), .TIMEOUT(TO)) dut (
    .clk_i(clk), .rst_i(rst), .req_i(req_i), .add_i(add_i), .wen_i(wen_i),
    .be_i(be_i), .wdata_i(wdata_i), .id_i(id_i), .gnt_o(gnt_o),
    .r_valid_o(r_valid_o), .r_rdata_o(r_rdata_o), .r_id_o(r_id_o),
    .r_opc_o(r_opc_o), .cfg_req_o(cfg_req_o), .cfg_add_o(cfg_add_o),
    .cfg_wen_o(cfg_wen_o), .cfg_be_o(cfg_be_o), .cfg_data_o(cfg_data_o),
    .cfg_id_o(cfg_id_o), .cfg_gnt_i(cfg_gnt_i), .cfg_r_valid_i(cfg_r_valid_i),
    .cfg_r_data_i(cfg_r_data_i), .cfg_r_id_i(cfg_r_id_i), .busy_o(busy_o)
  );

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("[TB] FAIL %s got=0x%0h exp=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic randomizeFields();
    for (int i = 0; i < N; i++) begin
      add_i[i]   = $urandom;
      wen_i[i]   = 1'($urandom_range(0, 1));
      be_i[i]    = 4'($urandom);
      wdata_i[i] = $urandom;
      id_i[i]    = IDW'($urandom);
    end
  endtask

  // Round-robin rule: first asserted request at or after ptr_m, wrapping.
  function automatic int modelWinner(input logic [N-1:0] req);
    int w = -1;
    for (int i = 0; i < N; i++)
      if (w < 0 && req[(ptr_m + i) % N]) w = (ptr_m + i) % N;
    return w;
  endfunction

  task automatic checkQuiet(input string tag);
    checkOutput({tag, "_busy"}, 32'(busy_o), 32'd0);
    checkOutput({tag, "_cfg_req"}, 32'(cfg_req_o), 32'd0);
    checkOutput({tag, "_r_valid"}, 32'(r_valid_o), 32'd0);
    checkOutput({tag, "_r_opc"}, 32'(r_opc_o), 32'd0);
    checkOutput({tag, "_r_rdata"}, r_rdata_o, 32'd0);
    checkOutput({tag, "_r_id"}, 32'(r_id_o), 32'd0);
    checkOutput({tag, "_cfg_add"}, cfg_add_o, 32'd0);
    checkOutput({tag, "_cfg_id"}, 32'(cfg_id_o), 32'd0);
    checkOutput({tag, "_gnt"}, 32'(gnt_o), 32'd0);
  endtask

  task automatic doReset();
    @(negedge clk);
    rst = 1'b1; req_i = '0; cfg_gnt_i = 1'b0; cfg_r_valid_i = 1'b0;
    #1 checkQuiet("in_reset");
    @(negedge clk);
    rst = 1'b0;
    #1 checkQuiet("after_reset");
    ptr_m   = 0;
    epoch_m = 1'b0;
  endtask

  // One full transaction: grant delay g cycles, response r cycles after the
  // downstream grant, optional spurious response at cycle stale_k (0 = none).
  task automatic applyStimulus(input logic [N-1:0] req, input int g, input int r, input int stale_k);
    int win, kg, kr, end_k;
    bit timed_out;
    logic [31:0] e_add, e_wdata, rsp_data, e_rdata;
    logic e_wen;
    logic [3:0] e_be;
    logic [IDW-1:0] e_uid, e_cid;
    @(negedge clk);
    req_i = req;
    win = modelWinner(req);
    #1;
    checkOutput("gnt_idle", 32'(gnt_o), 32'(1) << win);
    checkOutput("busy_idle", 32'(busy_o), 32'd0);
    e_add = add_i[win]; e_wen = wen_i[win]; e_be = be_i[win];
    e_wdata = wdata_i[win]; e_uid = id_i[win];
    e_cid = IDW'({epoch_m, 4'(win)});
    ptr_m = (win + 1) % N;
    kg = 1 + g;
    kr = kg + r;
    timed_out = (kr > TO);
    end_k = timed_out ? TO : kr;
    rsp_data = $urandom;
    for (int k = 1; k <= end_k; k++) begin
      @(negedge clk);
      if (k == 1) randomizeFields();
      cfg_gnt_i = (k == kg);
      cfg_r_valid_i = 1'b0;
      cfg_r_id_i = IDW'($urandom);
      cfg_r_data_i = $urandom;
      if (k == kr) begin
        cfg_r_valid_i = 1'b1; cfg_r_id_i = e_cid; cfg_r_data_i = rsp_data;
      end else if (k == stale_k) begin
        cfg_r_valid_i = 1'b1;
        cfg_r_id_i = (k < kg) ? e_cid : (e_cid ^ IDW'(8'h10));
      end
      #1;
      checkOutput("gnt_busy", 32'(gnt_o), 32'd0);
      checkOutput("busy", 32'(busy_o), 32'd1);
      checkOutput("r_valid_busy", 32'(r_valid_o), 32'd0);
      checkOutput("cfg_req", 32'(cfg_req_o), 32'(k <= kg));
      if (k <= kg) begin
        checkOutput("cfg_add", cfg_add_o, e_add);
        checkOutput("cfg_wen", 32'(cfg_wen_o), 32'(e_wen));
        checkOutput("cfg_be", 32'(cfg_be_o), 32'(e_be));
        checkOutput("cfg_data", cfg_data_o, e_wdata);
        checkOutput("cfg_id", 32'(cfg_id_o), 32'(e_cid));
      end
    end
    @(negedge clk);
    cfg_gnt_i = 1'b0; cfg_r_valid_i = 1'b0;
    #1;
    e_rdata = timed_out ? 32'hBADACCE5 : rsp_data;
    checkOutput("r_valid", 32'(r_valid_o), 32'(1) << win);
    checkOutput("r_rdata", r_rdata_o, e_rdata);
    checkOutput("r_id", 32'(r_id_o), 32'(e_uid));
    checkOutput("r_opc", 32'(r_opc_o), 32'(timed_out));
    checkOutput("cfg_req_resp", 32'(cfg_req_o), 32'd0);
    checkOutput("gnt_resp", 32'(gnt_o), 32'd0);
    epoch_m = ~epoch_m;
    @(negedge clk);
    req_i = '0;
    #1;
    checkOutput("r_valid_after", 32'(r_valid_o), 32'd0);
    checkOutput("r_opc_after", 32'(r_opc_o), 32'd0);
    checkOutput("r_rdata_hold", r_rdata_o, e_rdata);
    checkOutput("r_id_hold", 32'(r_id_o), 32'(e_uid));
    checkOutput("busy_after", 32'(busy_o), 32'd0);
  endtask

  // Abandon a transaction in WAIT_R with reset, then replay its response late.
  task automatic midResetScenario();
    int win;
    logic [IDW-1:0] old_id;
    @(negedge clk);
    req_i = 9'b000100000;
    win = modelWinner(req_i);
    old_id = IDW'({epoch_m, 4'(win)});
    #1 checkOutput("mr_gnt", 32'(gnt_o), 32'(1) << win);
    @(negedge clk);
    req_i = '0; cfg_gnt_i = 1'b1;
    #1 checkOutput("mr_cfg_req", 32'(cfg_req_o), 32'd1);
    @(negedge clk);
    cfg_gnt_i = 1'b0; rst = 1'b1;
    #1 checkQuiet("mr_in_reset");
    @(negedge clk);
    rst = 1'b0; cfg_r_valid_i = 1'b1; cfg_r_id_i = old_id; cfg_r_data_i = 32'h12345678;
    #1 checkQuiet("mr_after_reset");
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      cfg_r_valid_i = (k == 0);
      #1;
      checkOutput("mr_no_resp", 32'(r_valid_o), 32'd0);
      checkOutput("mr_idle", 32'(busy_o), 32'd0);
    end
    ptr_m = 0;
    epoch_m = 1'b0;
  endtask

  initial begin
    logic [N-1:0] rreq;
    rst = 1'b1; req_i = '0; cfg_gnt_i = 1'b0; cfg_r_valid_i = 1'b0;
    cfg_r_data_i = '0; cfg_r_id_i = '0;
    randomizeFields();
    repeat (2) @(negedge clk);
    doReset();

    $display("[TB] single write");
    add_i[3] = 32'h10; wdata_i[3] = 32'hCAFE; wen_i[3] = 1'b0;
    applyStimulus(9'b000001000, 0, 1, 0);

    $display("[TB] round robin");
    doReset();
    for (int t = 0; t < 3; t++) applyStimulus('1, 0, 1, 0);
    for (int t = 0; t < 4; t++) applyStimulus(9'b100000001, 0, 1, 0);

    $display("[TB] stale id, response on the timeout cycle");
    applyStimulus(9'b000010000, 0, 3, 2);
    applyStimulus(9'b011000000, 1, 0, 1);

    $display("[TB] timeout");
    applyStimulus(9'b000000100, 9, 0, 0);
    applyStimulus(9'b000000100, 1, 5, 3);

    $display("[TB] reset mid-transaction");
    applyStimulus(9'b000000010, 0, 1, 0);
    midResetScenario();
    applyStimulus('1, 0, 1, 0);

    $display("[TB] random traffic");
    for (int t = 0; t < 40; t++) begin
      randomizeFields();
      do rreq = N'($urandom); while (rreq == '0);
      applyStimulus(rreq, $urandom_range(0, 4), $urandom_range(0, 3), $urandom_range(0, 6));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
